// File: rtl/irq_encode_queue_if.sv
// Grant handshake bundle for irq_encode_queue.
// The overflow vector exists only when IRQ_OVERFLOW_EN is defined.
interface irq_encode_queue_if;
  logic       ready;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pending;
`ifdef IRQ_OVERFLOW_EN
  logic [7:0] overflow;

  modport master (output ready, input code, input valid, input pending, input overflow);
  modport slave  (input ready, output code, output valid, output pending, output overflow);
`else
  modport master (output ready, input code, input valid, input pending);
  modport slave  (input ready, output code, output valid, output pending);
`endif
endinterface

// File: rtl/irq_encode_queue.sv
// Eight-source interrupt synchroniser, edge detector, pending queue and priority grant FSM.
// Optional feature macro: IRQ_OVERFLOW_EN adds sticky per-source overflow flags.
module irq_encode_queue #(
  parameter int SYNC_STAGES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [7:0]         i_req,
  irq_encode_queue_if.slave  bus
);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_PRESENT = 1'b1;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_stages
    $error("irq_encode_queue: SYNC_STAGES must be 2 or 3");
  end

  logic [7:0] r_sync [SYNC_STAGES];
  logic [7:0] r_dly;
  logic [7:0] r_edge;
  logic [7:0] r_pending;
  logic [2:0] r_code;
  logic       r_valid;
  logic [0:0] r_state;

  logic [7:0] w_rise;
  logic [7:0] w_clr;
  logic [7:0] w_pend_nxt;
  logic       w_accept;

  function automatic logic [2:0] f_prio(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Stage: synchroniser chain; nothing else looks at i_req.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= 8'h00;
    end else begin
      r_sync[0] <= i_req;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  // Stage: edge detect against a delayed copy; edge pulse is registered.
  assign w_rise = r_sync[SYNC_STAGES-1] & ~r_dly;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dly  <= 8'h00;
      r_edge <= 8'h00;
    end else begin
      r_dly  <= r_sync[SYNC_STAGES-1];
      r_edge <= w_rise;
    end
  end

  // Stage: pending vector; a new edge beats the clear of the same bit.
  assign w_accept   = (r_state == S_PRESENT) && bus.ready;
  assign w_clr      = w_accept ? (8'd1 << r_code) : 8'h00;
  assign w_pend_nxt = (r_pending & ~w_clr) | r_edge;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_pending <= 8'h00;
    else          r_pending <= w_pend_nxt;
  end

  // Stage: grant FSM; code/valid frozen while presented and not accepted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_code  <= 3'd0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|r_pending) begin
            r_code  <= f_prio(r_pending);
            r_valid <= 1'b1;
            r_state <= S_PRESENT;
          end else begin
            r_valid <= 1'b0;
          end
        end
        S_PRESENT: begin
          if (bus.ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.code    = r_code;
  assign bus.valid   = r_valid;
  assign bus.pending = r_pending;

`ifdef IRQ_OVERFLOW_EN
  logic [7:0] r_ovf;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_ovf <= 8'h00;
    else          r_ovf <= r_ovf | (r_edge & r_pending & ~w_clr);
  end

  assign bus.overflow = r_ovf;
`endif

endmodule

// File: doc/irq_encode_queue.md
IRQ_ENCODE_QUEUE -- requirements
Module: irq_encode_queue

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchroniser flops per request line; legal values 2 or 3.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req  input  8  asynchronous request lines; bit n is source n.
REQ-005 ready  input  1  downstream accepts the current code.
REQ-006 code  output  3  index of the granted source, registered.
REQ-007 valid  output  1  code is valid, registered.
REQ-008 pending  output  8  registered pending-request vector.
REQ-009 overflow  output  8  sticky per-source overflow flags; present only when IRQ_OVERFLOW_EN is defined.

Function
REQ-010 Each req bit SHALL pass through SYNC_STAGES flops before use; no other logic SHALL sample raw req.
REQ-011 A rising edge SHALL be detected by comparing the last synchroniser stage with a one-cycle-delayed copy of it; a level held high SHALL produce exactly one edge.
REQ-012 A detected edge on bit n SHALL set pending[n] on the next clock edge.
REQ-013 FSM states SHALL be IDLE and PRESENT; reset state is IDLE.
REQ-014 IDLE: if pending != 0, load code with the highest set index of pending (bit 7 = highest priority), set valid=1, go to PRESENT; otherwise stay in IDLE with valid=0.
REQ-015 PRESENT: code and valid SHALL hold stable while ready=0, regardless of new pending bits, including higher-priority ones.
REQ-016 PRESENT with ready=1: clear pending[code], set valid=0, and return to IDLE on that edge.
REQ-017 Throughput: at most one grant every 2 cycles; back-to-back pending sources are presented on alternate cycles while ready=1.
REQ-018 Latency: with the block in IDLE and pending=0, valid SHALL rise on the (SYNC_STAGES+3)th rising clk edge after req rises and stays high, i.e., edge 5 for SYNC_STAGES=2.
REQ-019 If a new edge on bit n coincides with the acceptance that clears pending[n], set SHALL win and pending[n] stays 1.
REQ-020 An edge on a bit that is already pending SHALL leave pending unchanged; the request is merged.
REQ-021 Width rule: code is 3 bits, and the encode of pending=0 is never presented.

Reset
REQ-022 While rst_n=0: code=3'd0, valid=0, pending=8'h00, overflow=8'h00, FSM=IDLE, all synchroniser and delay flops are 0.
REQ-023 Reset asserted mid-PRESENT SHALL drop valid immediately (asynchronously) and discard all pending requests.
REQ-024 A req line that is high when rst_n deasserts SHALL produce one edge after synchronisation, because the delay flops reset to 0.

Configuration
REQ-025 Macro IRQ_OVERFLOW_EN: when defined, the overflow port exists, and an edge on bit n while pending[n]=1 (and not being cleared that cycle) SHALL set overflow[n], which is sticky until reset.
REQ-026 When IRQ_OVERFLOW_EN is undefined, the overflow port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-027 Reset, then raise req=8'h20 with ready=1 -> valid=1 and code=5 on the 5th clk edge, valid=0 next cycle, pending=8'h00.
REQ-028 Raise req=8'h05 simultaneously with ready=1 -> code=2 presented, then code=0 presented two cycles later, then pending=8'h00.
REQ-029 With ready=0 and code=1 presented, raise req bit 6 -> code stays 1 and valid stays 1 until ready=1; code=6 is presented on the following grant.
REQ-030 Hold req bit 3 high for 20 cycles with ready=1 -> exactly one grant with code=3.
REQ-031 Pulse bit 4 twice while it is pending and ready=0 -> one grant for code=4; with IRQ_OVERFLOW_EN defined, overflow=8'h10.
REQ-032 Assert rst_n=0 while valid=1 -> valid=0 and pending=8'h00 with no clock edge; no grant after release unless req is high.
